// File: rtl/axi_stream_byte_packer_if.sv
// axi_stream_byte_packer_if: AXI-Stream beat bundle (valid/data/keep/last from master, ready from slave)
// Ports: none; signals valid, data[DATA_WD], keep[DATA_WD/8], last, ready; modports master/slave.
interface axi_stream_byte_packer_if #(
    parameter int DATA_WD = 32
);
    logic                 valid;
    logic [DATA_WD-1:0]   data;
    logic [DATA_WD/8-1:0] keep;
    logic                 last;
    logic                 ready;
    modport master (output valid, data, keep, last, input ready);
    modport slave (input valid, data, keep, last, output ready);
endinterface

// File: rtl/axi_stream_byte_packer.sv
// axi_stream_byte_packer: repacks a partially-kept AXI-Stream into full beats, last beat left-aligned
// Ports: clk, rst (sync active-high); up (slave: upstream beats, ready = backpressure);
//        dn (master: packed beats, registered); err_keep (sticky non-contiguous keep flag,
//        live only when PACKER_KEEP_CHECK_EN is defined, otherwise tied 0).
module axi_stream_byte_packer #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_stream_byte_packer_if.slave  up,
    axi_stream_byte_packer_if.master dn,
    output logic                     err_keep
);
    localparam logic [CNT_WD:0] FULL = (CNT_WD + 1)'(DATA_BYTE_WD);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t                  state, state_nxt;
    logic [DATA_WD-1:0]      res, res_nxt, comp, e_data;
    logic [2*DATA_WD-1:0]    cat;
    logic [CNT_WD-1:0]       res_cnt, cnt_nxt, n;
    logic [CNT_WD:0]         t;
    logic [DATA_BYTE_WD-1:0] e_keep;
    logic                    acc, slot_free, emit, e_last, fin;

    function automatic logic [DATA_BYTE_WD-1:0] lmask(input logic [CNT_WD:0] c);
        return ~({DATA_BYTE_WD{1'b1}} >> c);
    endfunction

    // Gather kept bytes MSB-first so any keep pattern packs in byte order.
    always_comb begin
        comp = '0;
        n = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (up.keep[DATA_BYTE_WD-1-i]) begin
                comp[DATA_WD-1-8*int'(n) -: 8] = up.data[DATA_WD-1-8*i -: 8];
                n = n + 1'b1;
            end
        end
    end

    // Residue followed by new bytes; upper half is the candidate beat, lower half the carry.
    assign cat       = {res, {DATA_WD{1'b0}}} | ({comp, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});
    assign t         = {1'b0, res_cnt} + {1'b0, n};
    assign slot_free = !dn.valid || dn.ready;
    assign up.ready  = !rst && state == RUN && slot_free;
    assign acc       = up.valid && up.ready;
    assign fin       = up.last && t <= FULL;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == RUN ? ((acc && up.last && t > FULL) ? FLUSH : RUN)
                                 : (slot_free ? RUN : FLUSH);
    end

    always_comb begin
        emit = 1'b0;
        e_data = cat[2*DATA_WD-1 -: DATA_WD];
        e_keep = '1;
        e_last = 1'b0;
        res_nxt = res;
        cnt_nxt = res_cnt;
        if (state == FLUSH) begin
            emit = slot_free;
            e_data = res;
            e_keep = lmask({1'b0, res_cnt});
            e_last = 1'b1;
            res_nxt = slot_free ? '0 : res;
            cnt_nxt = slot_free ? '0 : res_cnt;
        end else if (acc && (up.last || t >= FULL)) begin
            emit = 1'b1;
            e_keep = fin ? lmask(t) : '1;
            e_last = fin;
            res_nxt = fin ? '0 : cat[DATA_WD-1:0];
            cnt_nxt = fin ? '0 : CNT_WD'(t - FULL);
        end else if (acc && |up.keep) begin
            res_nxt = cat[2*DATA_WD-1 -: DATA_WD];
            cnt_nxt = CNT_WD'(t);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            res_cnt <= '0;
            dn.valid <= 1'b0;
            dn.data <= '0;
            dn.keep <= '0;
            dn.last <= 1'b0;
        end else begin
            res <= res_nxt;
            res_cnt <= cnt_nxt;
            if (slot_free) begin
                dn.valid <= emit;
                if (emit) begin
                    dn.data <= e_data;
                    dn.keep <= e_keep;
                    dn.last <= e_last;
                end
            end
        end
    end

`ifdef PACKER_KEEP_CHECK_EN
    logic [DATA_BYTE_WD-1:0] low;
    // Adding the lowest set bit clears a contiguous run; any overlap left means a gap.
    assign low = up.keep & (~up.keep + 1'b1);
    always_ff @(posedge clk) begin
        if (rst) err_keep <= 1'b0;
        else if (acc && |(up.keep & (up.keep + low))) err_keep <= 1'b1;
    end
`else
    assign err_keep = 1'b0;
`endif
endmodule

// File: doc/axi_stream_byte_packer.md
Name: axi_stream_byte_packer

Overview:
- Sits directly downstream of the header-insertion stage.
- Consumes an AXI-Stream whose beats may carry partial byte enables, e.g. a short header beat followed by payload. Emits a densely packed stream: every beat full except the final beat of a packet, which is left-aligned.
- Lets downstream consumers (DMA, MAC framer) assume keep is all ones until last.

Parameters:
DATA_WD, 32, data bus width in bits (multiple of 8)
DATA_BYTE_WD, DATA_WD/8, bytes per beat
CNT_WD, $clog2(DATA_BYTE_WD)+1, width of byte counts 0..DATA_BYTE_WD

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
valid_in  input  1  upstream beat valid
data_in  input  DATA_WD  upstream data; byte 0 = data_in[DATA_WD-1 -: 8], first on wire
keep_in  input  DATA_BYTE_WD  byte enables; keep_in[DATA_BYTE_WD-1] qualifies byte 0
last_in  input  1  final beat of packet
ready_in  output  1  backpressure to upstream
valid_out  output  1  output beat valid
data_out  output  DATA_WD  packed data; unused bytes driven 0
keep_out  output  DATA_BYTE_WD  all ones, or left-aligned 1..10..0 on last beat
last_out  output  1  final beat of packet
ready_out  input  1  downstream ready
err_keep  output  1  sticky keep-format error (see Optional Feature)

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high. Handshake completes when valid && ready on a rising edge.
- Input keep rule: valid bytes within a beat are contiguous (any run position). The packer extracts the run, shifts it to the MSB end, and appends it behind residue bytes.
- State:
  - residue register: up to DATA_BYTE_WD-1 bytes, MSB-aligned.
  - res_cnt (CNT_WD bits).
  - registered output stage (valid_out/data_out/keep_out/last_out).
  - FSM states RUN and FLUSH.
- Reset: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0 during reset, res_cnt=0, FSM=RUN, err_keep=0. ready_in rises the cycle after rst deasserts.
- ready_in = (FSM==RUN) && (!valid_out || ready_out), combinational. Output registers load only when the output slot is empty or being accepted. Output holds stable while valid_out && !ready_out.
- RUN, on accepted input with n = popcount(keep_in), t = res_cnt + n:
  - t < DATA_BYTE_WD, not last: bytes go to residue, res_cnt = t, no output beat.
  - t >= DATA_BYTE_WD, not last: emit full beat (residue + first DATA_BYTE_WD-res_cnt new bytes), keep all ones, last=0. Remaining t-DATA_BYTE_WD bytes become residue.
  - last, t <= DATA_BYTE_WD: emit beat with t left-aligned keep bits, last=1, res_cnt=0.
  - last, t > DATA_BYTE_WD: emit full beat (last=0), store remainder, go to FLUSH.
  - keep_in==0, not last: beat dropped, no state change except error check.
  - keep_in==0 with last: flush residue with last=1. If res_cnt==0, emit one beat keep=0, last=1.
- FLUSH: ready_in=0. When the output slot is free, emit residue with keep = res_cnt left-aligned ones, last=1. Set res_cnt=0 and return to RUN.
- Latency: input beat to corresponding output beat is 1 cycle.
- Throughput: 1 beat/cycle, except one extra bubble on the input side for last beats with t > DATA_BYTE_WD.
- Packets never merge: residue is always empty at packet start.
- Reset mid-packet: all state and residue discarded, partial packet lost, valid_out=0 the next cycle.
- Output data bytes beyond keep_out are driven 0.

Optional Feature:
- Macro PACKER_KEEP_CHECK_EN.
- Defined:
  - A non-contiguous keep_in on an accepted beat sets err_keep (sticky until rst).
  - That beat's bytes are still packed by popcount order, MSB to LSB.
- Undefined:
  - No check logic.
  - err_keep tied 0.
  - Non-contiguous keep is unsupported and output bytes are unspecified.

Test Plan:
- DATA_WD=32. Input (0x0000AABB keep 0011), (0x11223344 keep 1111), (0x5566xxxx keep 1100 last) -> out (0xAABB1122 keep 1111 last 0), (0x33445566 keep 1111 last 1).
- Input (0x0000AABB keep 0011), (0x11223344 keep 1111 last) -> out (0xAABB1122 keep 1111), then (0x33440000 keep 1100 last 1). ready_in low exactly one cycle during FLUSH.
- Full beats 0xDEADBEEF, 0x01020304 last, keep 1111, ready_out held 1 -> identical output 1 cycle later, no bubbles. Hold ready_out=0 for 3 cycles mid-packet -> data_out stable, ready_in=0, no byte loss.
- Single beat (0x00CC0000 keep 0100 last) -> out 0xCC000000 keep 1000 last 1. Beat keep 0000 non-last mid-packet -> dropped, next output unchanged.
- Assert rst for 1 cycle with res_cnt=2 mid-packet -> valid_out=0, res_cnt=0. Next packet (0xA1A2A3A4 keep 1111 last) -> out 0xA1A2A3A4 with no stale bytes.
- With PACKER_KEEP_CHECK_EN: keep_in=1010 accepted -> err_keep=1 next cycle and stays 1 until rst. Without the macro -> err_keep stays 0.
